// File: rtl/vc_test_multi_rand_delay.sv
// vc_test_multi_rand_delay
// N-channel val/rdy delay element for test harnesses. Each channel owns a
// seedable 32-bit Galois LFSR and a down-counter; while the counter is zero the
// channel is a combinational pass-through, otherwise the message is held off
// until the counter drains. Payloads are never modified.
// Optional feature macro: VC_TEST_MULTI_RAND_DELAY_STATS_EN builds the
// saturating transfer/stall counters; without it the stat ports are tied to 0.

module vc_test_multi_rand_delay #(
  parameter int p_msg_nbits = 8,
  parameter int p_nchan     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     mode,
  input  logic [31:0]                    min_delay,
  input  logic [31:0]                    max_delay,
  input  logic [31:0]                    seed,
  input  logic [p_nchan-1:0]             in_val,
  output logic [p_nchan-1:0]             in_rdy,
  input  logic [p_nchan*p_msg_nbits-1:0] in_msg,
  output logic [p_nchan-1:0]             out_val,
  input  logic [p_nchan-1:0]             out_rdy,
  output logic [p_nchan*p_msg_nbits-1:0] out_msg,
  output logic [31:0]                    stat_xfers,
  output logic [31:0]                    stat_stall
);

  typedef enum logic [1:0] {
    MODE_ZERO  = 2'd0,
    MODE_FIXED = 2'd1,
    MODE_RAND  = 2'd2,
    MODE_RANGE = 2'd3
  } mode_e;

  // Galois taps for x^32+x^22+x^2+x+1 in right-shift form
  localparam logic [31:0] LFSR_TAPS   = 32'h80200003;
  // Golden-ratio constant spreads the shared seed across channels
  localparam logic [31:0] SEED_SPREAD = 32'h9E3779B9;

  mode_e              cur_mode;
  logic [p_nchan-1:0] idle;
  logic [p_nchan-1:0] xfer;

  assign cur_mode = mode_e'(mode);

  function automatic logic [31:0] lfsr_next(input logic [31:0] r);
    return {1'b0, r[31:1]} ^ (r[0] ? LFSR_TAPS : 32'd0);
  endfunction

  // An all-zero LFSR would lock up, so a zero seed result becomes 1
  function automatic logic [31:0] lfsr_seed(input logic [31:0] s, input int chan);
    logic [31:0] v;
    v = s ^ (32'(chan) * SEED_SPREAD);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  // The +1 on the modulus wraps to zero for full-range bounds; those cases
  // take the raw LFSR value instead of dividing by zero
  function automatic logic [31:0] draw_delay(input mode_e m, input logic [31:0] r,
                                             input logic [31:0] lo, input logic [31:0] hi);
    logic [31:0] d;
    logic [31:0] span;
    d    = 32'd0;
    span = hi - lo + 32'd1;
    case (m)
      MODE_ZERO:  d = 32'd0;
      MODE_FIXED: d = hi;
      MODE_RAND: begin
        if (hi == 32'd0)             d = 32'd0;
        else if (hi == 32'hFFFFFFFF) d = r;
        else                         d = r % (hi + 32'd1);
      end
      MODE_RANGE: begin
        if (lo >= hi)          d = lo;
        else if (span == 32'd0) d = lo + r;
        else                   d = lo + (r % span);
      end
      default: d = 32'd0;
    endcase
    return d;
  endfunction

  for (genvar i = 0; i < p_nchan; i++) begin : g_chan
    logic [31:0] cnt_q;
    logic [31:0] lfsr_q;
    logic [31:0] draw;

    assign idle[i]    = (cnt_q == 32'd0);
    assign xfer[i]    = in_val[i] && out_rdy[i] && idle[i];
    assign out_val[i] = !reset && in_val[i] && idle[i];
    assign in_rdy[i]  = !reset && out_rdy[i] && idle[i];
    assign out_msg[i*p_msg_nbits +: p_msg_nbits] =
      out_val[i] ? in_msg[i*p_msg_nbits +: p_msg_nbits] : '0;
    assign draw = draw_delay(cur_mode, lfsr_q, min_delay, max_delay);

    // Load a fresh delay on each transfer, drain only while a message waits
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q  <= 32'd0;
        lfsr_q <= lfsr_seed(seed, i);
      end else if (xfer[i]) begin
        cnt_q  <= draw;
        lfsr_q <= lfsr_next(lfsr_q);
      end else if (in_val[i] && !idle[i]) begin
        cnt_q  <= cnt_q - 32'd1;
      end
    end
  end

`ifdef VC_TEST_MULTI_RAND_DELAY_STATS_EN
  logic [31:0] xfers_q;
  logic [31:0] stall_q;
  logic [5:0]  xfer_count;
  logic [32:0] xfers_sum;
  logic        any_stall;

  // Count this cycle's transfers and detect any waiting channel
  always_comb begin
    xfer_count = 6'd0;
    for (int i = 0; i < p_nchan; i++) begin
      xfer_count = xfer_count + {5'd0, xfer[i]};
    end
    xfers_sum = {1'b0, xfers_q} + {27'd0, xfer_count};
    any_stall = |(in_val & ~idle);
  end

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      xfers_q <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      xfers_q <= xfers_sum[32] ? 32'hFFFFFFFF : xfers_sum[31:0];
      if (any_stall && stall_q != 32'hFFFFFFFF) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign stat_xfers = xfers_q;
  assign stat_stall = stall_q;
`else
  assign stat_xfers = 32'd0;
  assign stat_stall = 32'd0;
`endif

  // Control and handshake signals must be known whenever out of reset
  assert property (@(posedge clk) disable iff (reset)
    !$isunknown({mode, in_val, out_rdy, in_rdy, out_val}));

endmodule

// File: tb/tb_vc_test_multi_rand_delay.sv
// tb_vc_test_multi_rand_delay
// Directed bench for the two-channel delay element: a table of per-cycle
// vectors for the fixed/zero/range modes, plus hand-written sequences for
// the pseudo-random trace, output back-pressure and reset mid-delay.

module tb_vc_test_multi_rand_delay;

  localparam int NB = 8;
  localparam int NC = 2;
  localparam int NMSG = 200;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [31:0]   min_delay = 32'd0;
  logic [31:0]   max_delay = 32'd0;
  logic [31:0]   seed = 32'd0;
  logic [NC-1:0] in_val = '0;
  logic [NC-1:0] in_rdy;
  logic [NC*NB-1:0] in_msg = '0;
  logic [NC-1:0] out_val;
  logic [NC-1:0] out_rdy = '0;
  logic [NC*NB-1:0] out_msg;
  logic [31:0]   stat_xfers;
  logic [31:0]   stat_stall;

  vc_test_multi_rand_delay #(.p_msg_nbits(NB), .p_nchan(NC)) dut (
    .clk(clk), .reset(reset), .mode(mode), .min_delay(min_delay),
    .max_delay(max_delay), .seed(seed), .in_val(in_val), .in_rdy(in_rdy),
    .in_msg(in_msg), .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
    .stat_xfers(stat_xfers), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] min_d;
    logic [31:0] max_d;
    logic [1:0]  in_val;
    logic [1:0]  out_rdy;
    logic [15:0] in_msg;
    logic [1:0]  exp_val;
    logic [1:0]  exp_rdy;
    logic [15:0] exp_msg;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;
  int   traces[3][NMSG];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    mode      = v.mode;
    min_delay = v.min_d;
    max_delay = v.max_d;
    in_val    = v.in_val;
    out_rdy   = v.out_rdy;
    in_msg    = v.in_msg;
    #1;
  endtask

  // Channel 0 carries msg: 'stalls' held cycles, then the cycle it passes
  task automatic addGap(input logic [1:0] m, input logic [31:0] lo, input logic [31:0] hi,
                        input logic [7:0] msg, input int stalls);
    vec_t v;
    v.mode = m; v.min_d = lo; v.max_d = hi;
    v.in_val = 2'b01; v.out_rdy = 2'b11; v.in_msg = {8'h00, msg};
    for (int s = 0; s < stalls; s++) begin
      v.exp_val = 2'b00; v.exp_rdy = 2'b10; v.exp_msg = 16'h0000;
      vecs.push_back(v);
    end
    v.exp_val = 2'b01; v.exp_rdy = 2'b11; v.exp_msg = {8'h00, msg};
    vecs.push_back(v);
  endtask

  task automatic doReset(input logic [31:0] s);
    @(negedge clk);
    reset = 1'b1; seed = s; in_val = 2'b11; out_rdy = 2'b11; in_msg = 16'hC3C3;
    #1;
    checkOutput("rst_out_val", {30'd0, out_val}, 32'd0);
    checkOutput("rst_in_rdy", {30'd0, in_rdy}, 32'd0);
    checkOutput("rst_out_msg", {16'd0, out_msg}, 32'd0);
    @(negedge clk);
    reset = 1'b0; in_val = 2'b00;
    #1;
    checkOutput("rst_stat_xfers", stat_xfers, 32'd0);
    checkOutput("rst_stat_stall", stat_stall, 32'd0);
  endtask

  // Stream NMSG messages on channel 0 in mode 2 and record each gap
  task automatic runTrace(input int which);
    for (int m = 0; m < NMSG; m++) begin
      int gap;
      bit done;
      gap = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        mode = 2'd2; min_delay = 32'd0; max_delay = 32'd5;
        in_val = 2'b01; out_rdy = 2'b11; in_msg = {8'h00, 8'(m)};
        #1;
        if (out_val[0]) begin
          done = 1'b1;
          checkOutput($sformatf("t3_msg%0d", m), {16'd0, out_msg}, {24'd0, 8'(m)});
        end else if (gap >= 12) begin
          done = 1'b1;
          checks++;
          failures++;
          $display("[TB] FAIL t3_timeout msg %0d: waited %0d cycles, required at most 5", m, gap);
        end else begin
          gap++;
        end
      end
      traces[which][m] = gap;
      checkOutput($sformatf("t3_gap_range%0d", m), {31'd0, gap <= 5}, 32'd1);
    end
    checkOutput("t3_first_gap", 32'(traces[which][0]), 32'd0);
    @(negedge clk);
    in_val = 2'b00;
  endtask

  initial begin
    int t2_len;
    int diff_ab;
    int diff_ac;

    // T2: fixed delay 3, four back-to-back messages
    addGap(2'd1, 32'd0, 32'd3, 8'hA0, 0);
    addGap(2'd1, 32'd0, 32'd3, 8'hA1, 3);
    addGap(2'd1, 32'd0, 32'd3, 8'hA2, 3);
    addGap(2'd1, 32'd0, 32'd3, 8'hA3, 3);
    t2_len = vecs.size();
    // Drain the pending count left by A3 with a mode-0 draw
    addGap(2'd0, 32'd0, 32'd0, 8'hB0, 3);
    // T1: zero delay stream 0x11..0x1F, channel 1 idle
    for (int k = 1; k <= 15; k++) addGap(2'd0, 32'd0, 32'd0, 8'(8'h10 + k), 0);
    // T4: range with min==max, then min>max; the change mid-delay hits the next draw only
    addGap(2'd3, 32'd2, 32'd2, 8'hC0, 0);
    addGap(2'd3, 32'd2, 32'd2, 8'hC1, 2);
    addGap(2'd3, 32'd2, 32'd2, 8'hC2, 2);
    addGap(2'd3, 32'd7, 32'd4, 8'hD0, 2);
    addGap(2'd3, 32'd7, 32'd4, 8'hD1, 7);
    addGap(2'd3, 32'd7, 32'd4, 8'hD2, 7);

    doReset(32'h00001234);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_out_val", i), {30'd0, out_val}, {30'd0, vecs[i].exp_val});
      checkOutput($sformatf("v%0d_in_rdy", i), {30'd0, in_rdy}, {30'd0, vecs[i].exp_rdy});
      checkOutput($sformatf("v%0d_out_msg", i), {16'd0, out_msg}, {16'd0, vecs[i].exp_msg});
      if (i == t2_len - 1) begin
        @(posedge clk);
        #1;
`ifdef VC_TEST_MULTI_RAND_DELAY_STATS_EN
        checkOutput("t2_stat_xfers", stat_xfers, 32'd4);
        checkOutput("t2_stat_stall", stat_stall, 32'd9);
`else
        checkOutput("t2_stat_xfers", stat_xfers, 32'd0);
        checkOutput("t2_stat_stall", stat_stall, 32'd0);
`endif
      end
    end

    // T3 first run
    doReset(32'h0000ACE1);
    runTrace(0);

    // T5: channel 1 waits 2 cycles, then is back-pressured for 10 cycles
    doReset(32'h00005555);
    @(negedge clk);
    mode = 2'd1; max_delay = 32'd2; in_val = 2'b10; out_rdy = 2'b11; in_msg = 16'h5900;
    #1;
    checkOutput("t5_first_val", {30'd0, out_val}, 32'h2);
    checkOutput("t5_first_msg", {16'd0, out_msg}, 32'h5900);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_msg = 16'h5A00;
      #1;
      checkOutput($sformatf("t5_wait%0d_val", c), {30'd0, out_val}, 32'h0);
      checkOutput($sformatf("t5_wait%0d_rdy", c), {30'd0, in_rdy}, 32'h1);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      mode = 2'd0; in_val = 2'b11; out_rdy = 2'b01; in_msg = {8'h5A, 8'(8'h60 + c)};
      #1;
      checkOutput($sformatf("t5_hold%0d_val", c), {30'd0, out_val}, 32'h3);
      checkOutput($sformatf("t5_hold%0d_rdy", c), {30'd0, in_rdy}, 32'h1);
      checkOutput($sformatf("t5_hold%0d_msg", c), {16'd0, out_msg}, {16'd0, 8'h5A, 8'(8'h60 + c)});
    end
    @(negedge clk);
    out_rdy = 2'b11; in_msg = 16'h5A6A;
    #1;
    checkOutput("t5_drain_rdy", {30'd0, in_rdy}, 32'h3);
    checkOutput("t5_drain_msg", {16'd0, out_msg}, 32'h5A6A);
    @(negedge clk);
    in_val = 2'b01; in_msg = 16'h006B;
    #1;
    checkOutput("t5_after_val", {30'd0, out_val}, 32'h1);

    // T6: load cnt[0]=4, then reset during the delay and replay the T3 seed
    @(negedge clk);
    mode = 2'd1; max_delay = 32'd4; in_val = 2'b01; out_rdy = 2'b11; in_msg = 16'h0077;
    #1;
    checkOutput("t6_xfer_val", {30'd0, out_val}, 32'h1);
    doReset(32'h0000ACE1);
    runTrace(1);
    doReset(32'h0000ACE2);
    runTrace(2);

    diff_ab = 0;
    diff_ac = 0;
    for (int m = 0; m < NMSG; m++) begin
      if (traces[0][m] != traces[1][m]) diff_ab++;
      if (traces[0][m] != traces[2][m]) diff_ac++;
    end
    checkOutput("t3_same_seed_diffs", 32'(diff_ab), 32'd0);
    checkOutput("t3_other_seed_differs", {31'd0, diff_ac != 0}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, bench did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
